// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with relative branching and a return-address stack.
// Sits at the head of the fetch stage and drives the instruction-memory address.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   PCDrive[2:0]    command: 000 hold, 001 step, 010 relative, 011 absolute,
//                   100 call, 101 return, 110 restart, 111 hold
//   PCSet[AW-1:0]   absolute target or signed relative offset
//   Stall           holds all state and suppresses the fetch strobe
//   PCAddr          current fetch address
//   GetInstruction  one-cycle strobe after each accepted PC-changing command
//   StackEmpty/Full return-stack occupancy flags
//   StackErr        sticky: call on full or return on empty
//   AlignErr        sticky: misaligned target (only with PC_ALIGN_CHECK_EN)
// Build option: define PC_ALIGN_CHECK_EN to reject targets not aligned to STEP.
module pc_stack_unit #(
   parameter int AW = 32,
   parameter int STEP = 4,
   parameter int DEPTH = 4,
   parameter logic [AW-1:0] RESET_VECTOR = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2:0]    PCDrive,
   input  logic [AW-1:0] PCSet,
   input  logic          Stall,
   output logic [AW-1:0] PCAddr,
   output logic          GetInstruction,
   output logic          StackEmpty,
   output logic          StackFull,
   output logic          StackErr,
   output logic          AlignErr
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   localparam logic [AW-1:0] AMASK = AW'(STEP - 1);

   logic [AW-1:0] stk [DEPTH];
   logic [CW-1:0] count, nxt_cnt, cm1;
   logic [AW-1:0] nxt_pc, seq, target;
   logic          acc, push, nxt_serr, misal;

   assign seq        = PCAddr + AW'(STEP);
   assign target     = (PCDrive == 3'b010) ? PCAddr + PCSet : PCSet;
   assign cm1        = count - 1'b1;
   assign StackEmpty = (count == '0);
   assign StackFull  = (count == CW'(DEPTH));

`ifdef PC_ALIGN_CHECK_EN
   logic align_err;
   assign misal = (PCDrive == 3'b010 || PCDrive == 3'b011 || PCDrive == 3'b100) && |(target & AMASK);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) align_err <= 1'b0;
      else if (!Stall) align_err <= (PCDrive == 3'b110) ? 1'b0 : (align_err | misal);
   assign AlignErr = align_err;
`else
   assign misal    = 1'b0;
   assign AlignErr = 1'b0;
`endif

   always_comb begin
      nxt_pc   = PCAddr;
      nxt_cnt  = count;
      nxt_serr = StackErr;
      acc      = 1'b0;
      push     = 1'b0;
      if (!Stall)
         case (PCDrive)
            3'b001: begin nxt_pc = seq; acc = 1'b1; end
            3'b010, 3'b011:
               if (!misal) begin nxt_pc = target; acc = 1'b1; end
            3'b100: begin
               // a full stack and a misaligned target each reject the call
               nxt_serr = StackErr | StackFull;
               if (!StackFull && !misal) begin
                  push    = 1'b1;
                  nxt_pc  = PCSet;
                  nxt_cnt = count + 1'b1;
                  acc     = 1'b1;
               end
            end
            3'b101: begin
               nxt_serr = StackErr | StackEmpty;
               if (!StackEmpty) begin
                  nxt_pc  = stk[cm1[IW-1:0]];
                  nxt_cnt = cm1;
                  acc     = 1'b1;
               end
            end
            3'b110: begin
               nxt_pc   = RESET_VECTOR;
               nxt_cnt  = '0;
               nxt_serr = 1'b0;
               acc      = 1'b1;
            end
            default: ;
         endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         PCAddr         <= RESET_VECTOR;
         GetInstruction <= 1'b0;
         count          <= '0;
         StackErr       <= 1'b0;
      end else begin
         PCAddr         <= nxt_pc;
         GetInstruction <= acc;
         count          <= nxt_cnt;
         StackErr       <= nxt_serr;
      end

   // stack RAM needs no reset: the count register defines what is valid
   always_ff @(posedge clk)
      if (push) stk[count[IW-1:0]] <= seq;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed self-checking bench for pc_stack_unit.
module tb_pc_stack_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  PCDrive = 3'b000;
   logic [31:0] PCSet = '0;
   logic        Stall = 1'b0;
   logic [31:0] PCAddr;
   logic        GetInstruction, StackEmpty, StackFull, StackErr, AlignErr;
   int          errors = 0;
   int          checks = 0;

   pc_stack_unit #(.AW(32), .STEP(4), .DEPTH(4), .RESET_VECTOR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .PCDrive(PCDrive), .PCSet(PCSet), .Stall(Stall),
      .PCAddr(PCAddr), .GetInstruction(GetInstruction), .StackEmpty(StackEmpty),
      .StackFull(StackFull), .StackErr(StackErr), .AlignErr(AlignErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cmd(input logic [2:0] d, input logic [31:0] s);
      PCDrive = d;
      PCSet = s;
      @(posedge clk);
      #1;
      PCDrive = 3'b000;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", PCAddr, 32'h0);
      chk("rst_gi", GetInstruction, 0);
      chk("rst_empty", StackEmpty, 1);
      chk("rst_full", StackFull, 0);
      chk("rst_serr", StackErr, 0);
      chk("rst_aerr", AlignErr, 0);
      rst_n = 1'b1;
      // sequential stepping
      cmd(3'b001, 0); chk("inc1_pc", PCAddr, 32'h4); chk("inc1_gi", GetInstruction, 1);
      cmd(3'b001, 0); chk("inc2_pc", PCAddr, 32'h8); chk("inc2_gi", GetInstruction, 1);
      cmd(3'b001, 0); chk("inc3_pc", PCAddr, 32'hC); chk("inc3_gi", GetInstruction, 1);
      cmd(3'b000, 0); chk("hold_pc", PCAddr, 32'hC); chk("hold_gi", GetInstruction, 0);
      cmd(3'b111, 32'h1234); chk("rsv_pc", PCAddr, 32'hC); chk("rsv_gi", GetInstruction, 0);
      // absolute, relative and wrap
      cmd(3'b011, 32'h1000); chk("abs_pc", PCAddr, 32'h1000);
      cmd(3'b010, 32'hFFFF_FFF0); chk("rel_neg_pc", PCAddr, 32'h0FF0); chk("rel_gi", GetInstruction, 1);
      cmd(3'b011, 32'hFFFF_FFFC); chk("abs_top_pc", PCAddr, 32'hFFFF_FFFC);
      cmd(3'b001, 0); chk("wrap_pc", PCAddr, 32'h0); chk("wrap_gi", GetInstruction, 1);
      cmd(3'b011, 32'h0); chk("same_pc", PCAddr, 32'h0); chk("same_gi", GetInstruction, 1);
      // nested call / return
      cmd(3'b011, 32'h100);
      cmd(3'b100, 32'h200); chk("call1_pc", PCAddr, 32'h200); chk("call1_empty", StackEmpty, 0);
      cmd(3'b100, 32'h300); chk("call2_pc", PCAddr, 32'h300);
      cmd(3'b101, 0); chk("ret1_pc", PCAddr, 32'h204); chk("ret1_gi", GetInstruction, 1);
      cmd(3'b101, 0); chk("ret2_pc", PCAddr, 32'h104); chk("ret2_empty", StackEmpty, 1);
      chk("ret_serr", StackErr, 0);
      // overflow
      cmd(3'b011, 32'h0);
      cmd(3'b100, 32'h10);
      cmd(3'b100, 32'h20);
      cmd(3'b100, 32'h30); chk("c3_full", StackFull, 0);
      cmd(3'b100, 32'h40); chk("c4_full", StackFull, 1); chk("c4_pc", PCAddr, 32'h40);
      cmd(3'b100, 32'h50); chk("c5_pc", PCAddr, 32'h40); chk("c5_gi", GetInstruction, 0);
      chk("c5_serr", StackErr, 1); chk("c5_full", StackFull, 1);
      cmd(3'b101, 0); chk("ovf_ret_pc", PCAddr, 32'h34); chk("ovf_ret_full", StackFull, 0);
      chk("serr_sticky", StackErr, 1);
      cmd(3'b110, 0); chk("rs_pc", PCAddr, 32'h0); chk("rs_serr", StackErr, 0);
      chk("rs_empty", StackEmpty, 1); chk("rs_gi", GetInstruction, 1);
      // stall
      cmd(3'b011, 32'h80);
      Stall = 1'b1;
      cmd(3'b011, 32'h55); chk("stall_pc", PCAddr, 32'h80); chk("stall_gi", GetInstruction, 0);
      cmd(3'b110, 0); chk("stall_rs_pc", PCAddr, 32'h80);
      Stall = 1'b0;
      // async reset discards the stack
      cmd(3'b100, 32'h200);
      cmd(3'b100, 32'h300); chk("pre_rst_empty", StackEmpty, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pc", PCAddr, 32'h0); chk("arst_empty", StackEmpty, 1); chk("arst_gi", GetInstruction, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cmd(3'b101, 0); chk("uf_serr", StackErr, 1); chk("uf_pc", PCAddr, 32'h0); chk("uf_gi", GetInstruction, 0);
      cmd(3'b110, 0);
      // alignment
      cmd(3'b011, 32'h1002);
`ifdef PC_ALIGN_CHECK_EN
      chk("al_pc", PCAddr, 32'h0); chk("al_aerr", AlignErr, 1); chk("al_gi", GetInstruction, 0);
      cmd(3'b110, 0); chk("al_clr", AlignErr, 0);
`else
      chk("al_pc", PCAddr, 32'h1002); chk("al_aerr", AlignErr, 0); chk("al_gi", GetInstruction, 1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
